// File: rtl/valid_ready_pipe.sv
// DEPTH-stage valid/ready pipeline: pass-through ready (MODE=0) or registered-ready
// skid-buffer stages (MODE=1), with synchronous flush and a held-beat count.
module valid_ready_pipe #(
  parameter int DATA_W = 3,
  parameter int DEPTH  = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = $clog2(2*DEPTH+1)
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_up,
  input  logic [DATA_W-1:0] data_up,
  output logic              ready_up,
  output logic              valid_down,
  output logic [DATA_W-1:0] data_down,
  input  logic              ready_down,
  output logic [CNT_W-1:0]  occupancy
);
  logic             stage_rdy_up;
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign ready_up  = stage_rdy_up & ~rst & ~flush;
  assign in_fire   = valid_up & ready_up;
  assign out_fire  = valid_down & ready_down;
  assign cnt_d     = flush ? '0 : cnt_q + CNT_W'(in_fire) - CNT_W'(out_fire);
  assign occupancy = cnt_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  if (MODE == 0) begin : g_pass
    logic [DEPTH-1:0]             v_q, v_d, rdy, in_v;
    logic [DEPTH-1:0][DATA_W-1:0] d_q, d_d, in_d;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign in_v[gi] = valid_up & ~flush;
        assign in_d[gi] = data_up;
      end else begin : g_link
        assign in_v[gi] = v_q[gi-1];
        assign in_d[gi] = d_q[gi-1];
      end
      // Unrolled ready chain: blocked only if this stage and all after it are full and the slave stalls.
      assign rdy[gi] = ready_down | ~(&v_q[DEPTH-1:gi]);
      assign v_d[gi] = ~flush & (rdy[gi] ? in_v[gi] : v_q[gi]);
      assign d_d[gi] = (rdy[gi] & in_v[gi]) ? in_d[gi] : d_q[gi];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

    assign stage_rdy_up = rdy[0];
    assign valid_down   = v_q[DEPTH-1];
    assign data_down    = d_q[DEPTH-1];
  end else begin : g_skid
    logic [DEPTH-1:0]             mv_q, mv_d, sv_q, sv_d;
    logic [DEPTH-1:0]             in_v, nxt_rdy, drain, acc;
    logic [DEPTH-1:0][DATA_W-1:0] md_q, md_d, sd_q, sd_d, in_d;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign in_v[gi] = valid_up & ~flush;
        assign in_d[gi] = data_up;
      end else begin : g_link
        assign in_v[gi] = mv_q[gi-1];
        assign in_d[gi] = md_q[gi-1];
      end
      if (gi == DEPTH-1) begin : g_tail
        assign nxt_rdy[gi] = ready_down;
      end else begin : g_mid
        assign nxt_rdy[gi] = ~sv_q[gi+1];
      end
      assign drain[gi] = ~mv_q[gi] | nxt_rdy[gi];
      assign acc[gi]   = in_v[gi] & ~sv_q[gi];
      // A held skid beat always refills main when main empties, so main stays valid while skid is.
      assign mv_d[gi]  = ~flush & (sv_q[gi] | (drain[gi] ? acc[gi] : mv_q[gi]));
      assign sv_d[gi]  = ~flush & (sv_q[gi] ? ~drain[gi] : (acc[gi] & ~drain[gi]));
      assign md_d[gi]  = (sv_q[gi] & drain[gi]) ? sd_q[gi] :
                         (acc[gi] & drain[gi])  ? in_d[gi] : md_q[gi];
      assign sd_d[gi]  = (acc[gi] & ~drain[gi]) ? in_d[gi] : sd_q[gi];
    end

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        mv_q <= '0;
        sv_q <= '0;
        md_q <= '0;
        sd_q <= '0;
      end else begin
        mv_q <= mv_d;
        sv_q <= sv_d;
        md_q <= md_d;
        sd_q <= sd_d;
      end
    end

    assign stage_rdy_up = ~sv_q[0];
    assign valid_down   = mv_q[DEPTH-1];
    assign data_down    = md_q[DEPTH-1];
  end
endmodule

// File: tb/tb_valid_ready_pipe.sv
// Bench for valid_ready_pipe: one instance per mode, queue scoreboard plus directed
// and randomized stimulus.
module tb_valid_ready_pipe;
  localparam int DW    = 3;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(2*DEPTH+1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [1:0]               fl, vu, ru, vd, rd;
  logic [1:0][DW-1:0]       du, dd;
  logic [1:0][CW-1:0]       occ;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]      sbq [2][$];
  logic [1:0]         hold;
  logic [1:0][DW-1:0] hold_d;

  valid_ready_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(0)) u_pass (
    .sys_clk(clk), .rst(rst), .flush(fl[0]), .valid_up(vu[0]), .data_up(du[0]),
    .ready_up(ru[0]), .valid_down(vd[0]), .data_down(dd[0]), .ready_down(rd[0]),
    .occupancy(occ[0])
  );

  valid_ready_pipe #(.DATA_W(DW), .DEPTH(DEPTH), .MODE(1)) u_skid (
    .sys_clk(clk), .rst(rst), .flush(fl[1]), .valid_up(vu[1]), .data_up(du[1]),
    .ready_up(ru[1]), .valid_down(vd[1]), .data_down(dd[1]), .ready_down(rd[1]),
    .occupancy(occ[1])
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: queue of accepted beats per instance, compared at each negedge.
  task automatic monitor_step(input int m);
    int size;
    if (rst) begin
      check($sformatf("m%0d_rst_valid", m), vd[m], 0);
      check($sformatf("m%0d_rst_ready", m), ru[m], 0);
      check($sformatf("m%0d_rst_occ", m), occ[m], 0);
      sbq[m].delete();
      hold[m] = 1'b0;
      return;
    end
    size = sbq[m].size();
    check($sformatf("m%0d_occ", m), occ[m], size);
    if (hold[m]) begin
      check($sformatf("m%0d_hold_valid", m), vd[m], 1);
      check($sformatf("m%0d_hold_data", m), dd[m], hold_d[m]);
    end
    if (vd[m]) begin
      check($sformatf("m%0d_valid_has_beat", m), (size > 0), 1);
      if (size > 0) check($sformatf("m%0d_order", m), dd[m], sbq[m][0]);
    end
    if (fl[m])                check($sformatf("m%0d_ready_flush", m), ru[m], 0);
    else if (m == 0)          check("m0_ready", ru[m], ((size < DEPTH) || rd[m]) ? 1 : 0);
    else if (size == 2*DEPTH) check("m1_ready_full", ru[m], 0);
    else if (size < 2)        check("m1_ready_free", ru[m], 1);
    hold[m]   = vd[m] & ~rd[m] & ~fl[m];
    hold_d[m] = dd[m];
    if (vd[m] && rd[m] && size > 0) begin
      $display("%0t mode%0d out %0d", $time, m, dd[m]);
      void'(sbq[m].pop_front());
    end
    if (vu[m] && ru[m]) sbq[m].push_back(du[m]);
    if (fl[m]) sbq[m].delete();
  endtask

  initial begin
    hold   = '0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) monitor_step(m);
    end
  end

  task automatic idle_all();
    vu = '0;
    rd = '1;
    fl = '0;
    du = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    sample();
    for (int m = 0; m < 2; m++) begin
      check("reset_valid", vd[m], 0);
      check("reset_data", dd[m], 0);
      check("reset_ready", ru[m], 0);
      check("reset_occ", occ[m], 0);
    end
    next_cycle();
    rst = 1'b0;
    sample();
    check("release_ready_m0", ru[0], 1);
    check("release_ready_m1", ru[1], 1);

    // Stream through MODE0, data 1..7, two cycles of latency.
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      vu[0] = (k < 7);
      du[0] = DW'(k + 1);
      sample();
      if (k < 7) check("t1_ready", ru[0], 1);
      check("t1_valid", vd[0], (k >= 2 && k <= 8) ? 1 : 0);
      if (k >= 2 && k <= 8) check("t1_data", dd[0], k - 1);
    end
    idle_all();
    repeat (3) next_cycle();

    // Backpressure on MODE1: four accepted, fifth held until room opens.
    n = 1;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      rd[1] = 1'b0;
      vu[1] = 1'b1;
      du[1] = DW'(n);
      sample();
      if (ru[1]) n++;
    end
    check("t2_accepted", n - 1, 4);
    check("t2_occ", occ[1], 4);
    check("t2_full_ready", ru[1], 0);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      rd[1] = 1'b1;
      vu[1] = (n <= 5);
      du[1] = DW'(n);
      sample();
      if (ru[1] && vu[1]) n++;
      check("t2_out_valid", vd[1], 1);
      check("t2_out_data", dd[1], k + 1);
    end
    check("t2_all_in", n, 6);
    idle_all();
    repeat (3) next_cycle();

    // MODE0 full: combinational ready follows ready_down.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      rd[0] = 1'b0;
      vu[0] = 1'b1;
      du[0] = DW'(k + 2);
      sample();
      check("t3_fill_ready", ru[0], 1);
    end
    next_cycle();
    du[0] = 3'd4;
    sample();
    check("t3_occ", occ[0], 2);
    check("t3_full_ready", ru[0], 0);
    check("t3_valid", vd[0], 1);
    check("t3_data", dd[0], 2);
    next_cycle();
    rd[0] = 1'b1;
    sample();
    check("t3_emit_ready", ru[0], 1);
    check("t3_emit_valid", vd[0], 1);
    check("t3_emit_data", dd[0], 2);
    next_cycle();
    vu[0] = 1'b0;
    sample();
    check("t3_occ_same", occ[0], 2);
    check("t3_next_data", dd[0], 3);
    idle_all();
    repeat (4) next_cycle();

    // Flush MODE1 holding three beats while 6 is offered.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      rd[1] = 1'b0;
      vu[1] = 1'b1;
      du[1] = DW'(k + 1);
      sample();
      check("t4_fill_ready", ru[1], 1);
    end
    next_cycle();
    fl[1] = 1'b1;
    du[1] = 3'd6;
    sample();
    check("t4_occ_before", occ[1], 3);
    check("t4_flush_ready", ru[1], 0);
    next_cycle();
    fl[1] = 1'b0;
    vu[1] = 1'b0;
    sample();
    check("t4_occ_after", occ[1], 0);
    check("t4_valid_after", vd[1], 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      rd[1] = 1'b1;
      sample();
      check("t4_nothing_out", vd[1], 0);
    end
    idle_all();

    // Asynchronous reset with two beats held in MODE0.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      rd[0] = 1'b0;
      vu[0] = 1'b1;
      du[0] = DW'(k + 5);
    end
    next_cycle();
    vu[0] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5_valid_now", vd[0], 0);
    check("t5_ready_now", ru[0], 0);
    check("t5_occ_now", occ[0], 0);
    next_cycle();
    rst = 1'b0;
    rd  = '1;
    sample();
    check("t5_release_ready_m0", ru[0], 1);
    check("t5_release_ready_m1", ru[1], 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      sample();
      check("t5_no_partial", vd[0], 0);
    end

    // Random traffic with stalls and occasional flush on both instances.
    for (int k = 0; k < 1500; k++) begin
      next_cycle();
      for (int m = 0; m < 2; m++) begin
        vu[m] = ($urandom_range(0, 3) != 0);
        du[m] = DW'($urandom);
        rd[m] = ((k / 150) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
        fl[m] = ($urandom_range(0, 59) == 0);
      end
    end
    idle_all();
    repeat (10) next_cycle();
    sample();
    for (int m = 0; m < 2; m++) begin
      check("drain_occ", occ[m], 0);
      check("drain_queue", sbq[m].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
